// File: rtl/spgd_phase_accum.sv
// SPGD dither-phase accumulator: sums ADC samples over phases A and C of each
// A-B-C dither cycle and publishes both sums, counts and the saturated A-C difference.
//   state  | meaning
//   IDLE   | waiting for a fresh entry into phase A
//   ACC_A  | accumulating phase-A samples
//   WAIT_B | phase B, nothing accumulated
//   ACC_C  | accumulating phase-C samples; leaving to A publishes
module spgd_phase_accum #(
  parameter int ADC_WIDTH   = 14,
  parameter int ACC_WIDTH   = 32,
  parameter int CNT_WIDTH   = 24,
  parameter int BLANK_WIDTH = 16
) (
  input  logic                        ADC_CLK,
  input  logic                        RST,
  input  logic signed [ADC_WIDTH-1:0] ADC_IN,
  input  logic [1:0]                  PHASE,
  input  logic [BLANK_WIDTH-1:0]      BLANK,
  output logic signed [ACC_WIDTH-1:0] SUM_A,
  output logic signed [ACC_WIDTH-1:0] SUM_C,
  output logic [CNT_WIDTH-1:0]        CNT_A,
  output logic [CNT_WIDTH-1:0]        CNT_C,
  output logic signed [ACC_WIDTH-1:0] DIFF,
  output logic                        RESULT_VALID,
  output logic                        SAT,
  output logic                        SEQ_ERR
);

  localparam logic [1:0] PH_OFF = 2'b00;
  localparam logic [1:0] PH_A   = 2'b01;
  localparam logic [1:0] PH_B   = 2'b10;
  localparam logic [1:0] PH_C   = 2'b11;
  localparam logic [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC_A, WAIT_B, ACC_C} state_t;
  state_t state, state_nxt;

  logic [ADC_WIDTH-1:0]   adc_s1;
  logic [1:0]             ph_s1, ph_prev;
  logic [ACC_WIDTH-1:0]   sum_a_w, sum_c_w;
  logic [CNT_WIDTH-1:0]   cnt_a_w, cnt_c_w;
  logic [BLANK_WIDTH-1:0] blank_a, blank_c;
  logic                   sat_w;

  logic enter_a, enter_c, acc_a_en, acc_c_en, publish, seq_err;
  logic upd_a, upd_c, take, sum_ovf, cnt_full, sat_base, sat_next;
  logic [BLANK_WIDTH-1:0] blank_cur, blank_next;
  logic [ACC_WIDTH-1:0]   sum_base, sum_next, diff_sat;
  logic [CNT_WIDTH-1:0]   cnt_base, cnt_next;
  logic [ACC_WIDTH:0]     sample_ext, sum_wide, diff_wide;
  logic                   diff_ovf;

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (ph_s1 == PH_A && ph_prev != PH_A) state_nxt = ACC_A;
      ACC_A:  if (ph_s1 == PH_B) state_nxt = WAIT_B;
              else if (ph_s1 != PH_A) state_nxt = IDLE;
      WAIT_B: if (ph_s1 == PH_C) state_nxt = ACC_C;
              else if (ph_s1 == PH_A) state_nxt = ACC_A;
              else if (ph_s1 == PH_OFF) state_nxt = IDLE;
      ACC_C:  if (ph_s1 == PH_A) state_nxt = ACC_A;
              else if (ph_s1 != PH_C) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enter_a  = (state != ACC_A) && (state_nxt == ACC_A);
    enter_c  = (state != ACC_C) && (state_nxt == ACC_C);
    acc_a_en = (state == ACC_A) && (ph_s1 == PH_A);
    acc_c_en = (state == ACC_C) && (ph_s1 == PH_C);
    publish  = (state == ACC_C) && (ph_s1 == PH_A);
    // phase 00 is a clean abort, never a sequencing error
    seq_err  = ((state == ACC_A)  && (ph_s1 == PH_C)) ||
               ((state == WAIT_B) && (ph_s1 == PH_A)) ||
               ((state == ACC_C)  && (ph_s1 == PH_B)) ||
               ((state == IDLE)   && ph_s1[1] && (ph_s1 != ph_prev));
  end

  assign sample_ext = {{(ACC_WIDTH+1-ADC_WIDTH){adc_s1[ADC_WIDTH-1]}}, adc_s1};

  always_comb begin
    upd_a     = enter_a | acc_a_en;
    upd_c     = enter_c | acc_c_en;
    blank_cur = '0;
    sum_base  = '0;
    cnt_base  = '0;
    if (upd_a) begin
      blank_cur = enter_a ? BLANK : blank_a;
      sum_base  = enter_a ? '0 : sum_a_w;
      cnt_base  = enter_a ? '0 : cnt_a_w;
    end else if (upd_c) begin
      blank_cur = enter_c ? BLANK : blank_c;
      sum_base  = enter_c ? '0 : sum_c_w;
      cnt_base  = enter_c ? '0 : cnt_c_w;
    end
    sat_base   = enter_a ? 1'b0 : sat_w;
    take       = (upd_a | upd_c) && (blank_cur == '0);
    sum_wide   = {sum_base[ACC_WIDTH-1], sum_base} + sample_ext;
    sum_ovf    = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    cnt_full   = &cnt_base;
    sum_next   = sum_base;
    cnt_next   = cnt_base;
    blank_next = blank_cur;
    sat_next   = sat_base;
    if (blank_cur != '0) begin
      blank_next = blank_cur - BLANK_WIDTH'(1);
    end else if (take) begin
      sum_next = sum_ovf ? (sum_wide[ACC_WIDTH] ? SUM_MIN : SUM_MAX) : sum_wide[ACC_WIDTH-1:0];
      cnt_next = cnt_full ? cnt_base : cnt_base + CNT_WIDTH'(1);
      sat_next = sat_base | sum_ovf | cnt_full;
    end
    diff_wide = {sum_a_w[ACC_WIDTH-1], sum_a_w} - {sum_c_w[ACC_WIDTH-1], sum_c_w};
    diff_ovf  = diff_wide[ACC_WIDTH] ^ diff_wide[ACC_WIDTH-1];
    diff_sat  = diff_ovf ? (diff_wide[ACC_WIDTH] ? SUM_MIN : SUM_MAX) : diff_wide[ACC_WIDTH-1:0];
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      adc_s1       <= '0;
      ph_s1        <= PH_OFF;
      ph_prev      <= PH_OFF;
      sum_a_w      <= '0;
      sum_c_w      <= '0;
      cnt_a_w      <= '0;
      cnt_c_w      <= '0;
      blank_a      <= '0;
      blank_c      <= '0;
      sat_w        <= 1'b0;
      SUM_A        <= '0;
      SUM_C        <= '0;
      CNT_A        <= '0;
      CNT_C        <= '0;
      DIFF         <= '0;
      SAT          <= 1'b0;
      RESULT_VALID <= 1'b0;
      SEQ_ERR      <= 1'b0;
    end else begin
      adc_s1       <= ADC_IN;
      ph_s1        <= PHASE;
      ph_prev      <= ph_s1;
      RESULT_VALID <= publish;
      SEQ_ERR      <= seq_err;
      if (upd_a) begin
        blank_a <= blank_next;
        sum_a_w <= sum_next;
        cnt_a_w <= cnt_next;
      end
      if (upd_c) begin
        blank_c <= blank_next;
        sum_c_w <= sum_next;
        cnt_c_w <= cnt_next;
      end
      if (upd_a | upd_c) sat_w <= sat_next;
      // publish reads the finished cycle; a same-edge A entry only touches the working copy
      if (publish) begin
        SUM_A <= sum_a_w;
        SUM_C <= sum_c_w;
        CNT_A <= cnt_a_w;
        CNT_C <= cnt_c_w;
        DIFF  <= diff_sat;
        SAT   <= sat_w | diff_ovf;
      end
    end
  end

endmodule

// File: tb/tb_spgd_phase_accum.sv
// Bench for spgd_phase_accum: directed phase sequences with $urandom samples, checked
// against a per-phase summing model for a 32-bit and a 16-bit accumulator instance.
module tb_spgd_phase_accum;
  localparam logic [1:0] P_OFF = 2'b00;
  localparam logic [1:0] P_A   = 2'b01;
  localparam logic [1:0] P_B   = 2'b10;
  localparam logic [1:0] P_C   = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [13:0] adc = '0;
  logic [1:0] phase = P_OFF;
  logic [15:0] blank = '0;

  logic signed [31:0] sum_a, sum_c, diff;
  logic [23:0] cnt_a, cnt_c;
  logic rv, sat, seq_err;
  logic signed [15:0] sum_a16, sum_c16, diff16;
  logic [23:0] cnt_a16, cnt_c16;
  logic rv16, sat16, seq_err16;

  spgd_phase_accum dut (
    .ADC_CLK(clk), .RST(rst), .ADC_IN(adc), .PHASE(phase), .BLANK(blank),
    .SUM_A(sum_a), .SUM_C(sum_c), .CNT_A(cnt_a), .CNT_C(cnt_c), .DIFF(diff),
    .RESULT_VALID(rv), .SAT(sat), .SEQ_ERR(seq_err)
  );

  spgd_phase_accum #(.ACC_WIDTH(16)) dut16 (
    .ADC_CLK(clk), .RST(rst), .ADC_IN(adc), .PHASE(phase), .BLANK(blank),
    .SUM_A(sum_a16), .SUM_C(sum_c16), .CNT_A(cnt_a16), .CNT_C(cnt_c16), .DIFF(diff16),
    .RESULT_VALID(rv16), .SAT(sat16), .SEQ_ERR(seq_err16)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, rv_n = 0, rv16_n = 0, se_n = 0, se_exp = 0, rv_cyc = -1;
  int wid[2] = '{32, 16};
  longint wsa[2] = '{0, 0}, wsc[2] = '{0, 0};
  int wca = 0, wcc = 0;
  bit wsat[2] = '{0, 0};
  longint esa[2] = '{0, 0}, esc[2] = '{0, 0}, ediff[2] = '{0, 0};
  int eca = 0, ecc = 0;
  bit esat[2] = '{0, 0};
  bit pend = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint mx;
    mx = (longint'(1) <<< (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  task automatic step(input logic [1:0] ph, input int a);
    phase = ph;
    adc = 14'(a);
    @(posedge clk);
    #1;
    cyc++;
    if (rv) begin rv_n++; rv_cyc = cyc; end
    if (rv16) rv16_n++;
    if (seq_err) se_n++;
  endtask

  // one phase segment; samples past the blank window go into the model sums
  task automatic run_seg(input logic [1:0] ph, input int len, input int lo, input int hi);
    for (int i = 0; i < len; i++) begin
      int a;
      longint t;
      a = lo + int'($urandom_range(hi - lo));
      step(ph, a);
      if ((ph == P_A || ph == P_C) && i >= int'(blank)) begin
        if (ph == P_A) wca++; else wcc++;
        for (int k = 0; k < 2; k++) begin
          t = ((ph == P_A) ? wsa[k] : wsc[k]) + longint'(a);
          if (clampw(t, wid[k]) != t) wsat[k] = 1'b1;
          if (ph == P_A) wsa[k] = clampw(t, wid[k]); else wsc[k] = clampw(t, wid[k]);
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("sum_a", longint'(sum_a), esa[0]);
    check("sum_c", longint'(sum_c), esc[0]);
    check("diff", longint'(diff), ediff[0]);
    check("cnt_a", longint'(cnt_a), longint'(eca));
    check("cnt_c", longint'(cnt_c), longint'(ecc));
    check("sat", longint'(sat), longint'(esat[0]));
    check("sum_a16", longint'(sum_a16), esa[1]);
    check("sum_c16", longint'(sum_c16), esc[1]);
    check("diff16", longint'(diff16), ediff[1]);
    check("cnt_a16", longint'(cnt_a16), longint'(eca));
    check("sat16", longint'(sat16), longint'(esat[1]));
  endtask

  task automatic finish_cycle();
    longint d;
    for (int k = 0; k < 2; k++) begin
      d = wsa[k] - wsc[k];
      esa[k] = wsa[k];
      esc[k] = wsc[k];
      ediff[k] = clampw(d, wid[k]);
      esat[k] = wsat[k] || (ediff[k] != d);
    end
    eca = wca;
    ecc = wcc;
    pend = 1'b1;
  endtask

  // starts a fresh A phase; if a C phase just ended, checks the publish 2 edges in
  task automatic run_a(input int bl, input int len, input int lo, input int hi);
    int t0, n0, n16;
    blank = 16'(bl);
    for (int k = 0; k < 2; k++) begin wsa[k] = 0; wsc[k] = 0; wsat[k] = 1'b0; end
    wca = 0;
    wcc = 0;
    t0 = cyc + 1;
    n0 = rv_n;
    n16 = rv16_n;
    run_seg(P_A, len, lo, hi);
    if (pend) begin
      check("rv_count", longint'(rv_n), longint'(n0 + 1));
      check("rv16_count", longint'(rv16_n), longint'(n16 + 1));
      check("rv_latency", longint'(rv_cyc), longint'(t0 + 1));
      check_outputs();
      pend = 1'b0;
    end
  endtask

  task automatic clear_expect();
    for (int k = 0; k < 2; k++) begin esa[k] = 0; esc[k] = 0; ediff[k] = 0; esat[k] = 1'b0; end
    eca = 0;
    ecc = 0;
    pend = 1'b0;
  endtask

  initial begin
    int n0;
    // reset state
    repeat (2) step(P_OFF, 0);
    check("rst_rv", longint'(rv), 0);
    check("rst_seq_err", longint'(seq_err), 0);
    check_outputs();
    rst = 1'b0;
    repeat (3) step(P_OFF, 0);

    // basic cycle, BLANK=2, A=100, C=-50
    run_a(2, 10, 100, 100);
    run_seg(P_B, 5, 0, 0);
    run_seg(P_C, 10, -50, -50);
    finish_cycle();
    run_a(2, 10, 100, 100);
    check("s1_sum_a", longint'(sum_a), 800);
    check("s1_cnt_a", longint'(cnt_a), 8);
    check("s1_sum_c", longint'(sum_c), -400);
    check("s1_cnt_c", longint'(cnt_c), 8);
    check("s1_diff", longint'(diff), 1200);
    check("s1_sat", longint'(sat), 0);

    // same cycle aborted by phase 00 at the fifth C sample
    run_seg(P_B, 5, 0, 0);
    run_seg(P_C, 4, -50, -50);
    n0 = rv_n;
    run_seg(P_OFF, 6, 0, 0);
    check("abort_no_rv", longint'(rv_n), longint'(n0));
    check_outputs();

    // 16-bit saturation
    run_a(0, 10, 8191, 8191);
    run_seg(P_B, 3, 0, 0);
    run_seg(P_C, 2, 0, 0);
    finish_cycle();
    run_a(0, 4, 10, 10);
    check("s2_sum_a16", longint'(sum_a16), 32767);
    check("s2_diff16", longint'(diff16), 32767);
    check("s2_sat16", longint'(sat16), 1);
    check("s2_sum_a", longint'(sum_a), 81910);
    run_seg(P_OFF, 3, 0, 0);
    pend = 1'b0;

    // A->C sequencing error, then a clean cycle
    n0 = rv_n;
    run_a(1, 4, -8192, 8191);
    run_seg(P_C, 4, -8192, 8191);
    se_exp++;
    check("seq_err_count", longint'(se_n), longint'(se_exp));
    run_seg(P_OFF, 2, 0, 0);
    check("seq_no_rv", longint'(rv_n), longint'(n0));
    run_a(1, 6, -8192, 8191);
    run_seg(P_B, 4, 0, 0);
    run_seg(P_C, 6, -8192, 8191);
    finish_cycle();

    // BLANK longer than every phase
    run_a(20, 10, 500, 900);
    run_seg(P_B, 10, 0, 0);
    run_seg(P_C, 10, -900, -500);
    finish_cycle();
    run_a(1, 8, -8192, 8191);
    check("blank_cnt_a", longint'(cnt_a), 0);
    check("blank_diff", longint'(diff), 0);
    run_seg(P_B, 4, 0, 0);
    run_seg(P_C, 7, -8192, 8191);
    finish_cycle();
    run_a(3, 6, -8192, 8191);

    // reset in the middle of C
    run_seg(P_B, 3, 0, 0);
    run_seg(P_C, 4, 1000, 2000);
    n0 = rv_n;
    phase = P_OFF;
    rst = 1'b1;
    #1;
    clear_expect();
    check_outputs();
    check("rst_mid_rv", longint'(rv), 0);
    step(P_OFF, 0);
    rst = 1'b0;
    repeat (2) step(P_OFF, 0);
    check("rst_mid_no_rv", longint'(rv_n), longint'(n0));
    run_a(2, 7, -8192, 8191);
    run_seg(P_B, 3, 0, 0);
    run_seg(P_C, 7, -8192, 8191);
    finish_cycle();

    // back-to-back random cycles
    for (int c = 0; c < 6; c++) begin
      run_a(int'($urandom_range(4)), 3 + int'($urandom_range(9)), -8192, 8191);
      run_seg(P_B, 1 + int'($urandom_range(5)), -8192, 8191);
      run_seg(P_C, 3 + int'($urandom_range(9)), -8192, 8191);
      finish_cycle();
    end
    run_a(0, 4, -8192, 8191);
    n0 = rv_n;
    run_seg(P_OFF, 4, 0, 0);
    check("end_no_rv", longint'(rv_n), longint'(n0));
    check("end_seq_err", longint'(se_n), longint'(se_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
